// File: rtl/ysyx_22050710_ifu_fetch_if.sv
// Fetch-unit bundle: instruction SRAM read port, redirect input and decode-side
// instruction stream. The fetch unit uses the master modport.
interface ysyx_22050710_ifu_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32
);
    logic                  o_sram_en;
    logic [ADDR_WIDTH-1:0] o_sram_addr;
    logic [DATA_WIDTH-1:0] i_sram_rdata;
    logic                  i_sram_rvalid;
    logic                  i_redirect_valid;
    logic [ADDR_WIDTH-1:0] i_redirect_pc;
    logic                  o_inst_valid;
    logic [INST_WIDTH-1:0] o_inst;
    logic [ADDR_WIDTH-1:0] o_inst_pc;
    logic                  i_inst_ready;

    modport master (
        output o_sram_en, o_sram_addr, o_inst_valid, o_inst, o_inst_pc,
        input  i_sram_rdata, i_sram_rvalid, i_redirect_valid, i_redirect_pc, i_inst_ready
    );

    modport slave (
        input  o_sram_en, o_sram_addr, o_inst_valid, o_inst, o_inst_pc,
        output i_sram_rdata, i_sram_rvalid, i_redirect_valid, i_redirect_pc, i_inst_ready
    );
endinterface

// File: rtl/ysyx_22050710_ifu_fetch.sv
// Instruction fetch requester: one outstanding SRAM read, stale-response drop after
// redirect, small FIFO toward decode. YSYX_22050710_IFU_INST_BUF_EN selects a 2-entry FIFO.
module ysyx_22050710_ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000)
) (
    input logic i_clk,
    input logic i_rst_n,
    ysyx_22050710_ifu_fetch_if.master bus
);

`ifdef YSYX_22050710_IFU_INST_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CNT_W = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DROP = 3'd3,
        HOLD = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [INST_WIDTH-1:0] buf_inst_q [DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc_q   [DEPTH];

    logic                  redirect;
    logic                  rvalid;
    logic                  sram_en;
    logic                  push;
    logic                  pop;
    logic                  free_after_push;
    logic [CNT_W-1:0]      wr_idx;
    logic [DEPTH-1:0]      slot_load;
    logic [INST_WIDTH-1:0] fetched_inst;

    assign redirect = bus.i_redirect_valid;
    assign rvalid   = bus.i_sram_rvalid;
    assign pop      = (count_q != '0) && bus.i_inst_ready;

    // The 64-bit word holds two instructions; pc[2] picks the upper one.
    assign fetched_inst = pc_q[2] ? bus.i_sram_rdata[DATA_WIDTH-1 -: INST_WIDTH]
                                  : bus.i_sram_rdata[INST_WIDTH-1:0];

    // Pushes only happen with a free slot, so count - pop + 1 never overflows.
    assign free_after_push = (count_q - CNT_W'(pop) + CNT_W'(1)) < CNT_W'(DEPTH);
    assign wr_idx          = count_q - CNT_W'(pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sram_en = 1'b0;
        push    = 1'b0;
        if (redirect) begin
            pc_d = bus.i_redirect_pc;
        end
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (!redirect) begin
                    sram_en = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_d = rvalid ? REQ : DROP;
                end else if (rvalid) begin
                    push    = 1'b1;
                    pc_d    = pc_q + ADDR_WIDTH'(4);
                    state_d = free_after_push ? REQ : HOLD;
                end
            end
            DROP: begin
                if (rvalid) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect || (count_q < CNT_W'(DEPTH))) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Shift FIFO: head is always entry 0, a push lands just behind the survivors.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_load[gi] = push && (wr_idx == CNT_W'(gi));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_inst_q[i] <= '0;
                buf_pc_q[i]   <= RESET_PC;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_load[i]) begin
                    buf_inst_q[i] <= fetched_inst;
                    buf_pc_q[i]   <= pc_q;
                end else if (pop && (i < DEPTH - 1)) begin
                    buf_inst_q[i] <= buf_inst_q[(i + 1) % DEPTH];
                    buf_pc_q[i]   <= buf_pc_q[(i + 1) % DEPTH];
                end
            end
        end
    end

    assign bus.o_sram_en    = sram_en;
    assign bus.o_sram_addr  = pc_q;
    assign bus.o_inst_valid = (count_q != '0);
    assign bus.o_inst       = buf_inst_q[0];
    assign bus.o_inst_pc    = buf_pc_q[0];

endmodule

// File: tb/tb_ysyx_22050710_ifu_fetch.sv
// Bench for ysyx_22050710_ifu_fetch: memory-backed SRAM model with random latency,
// instruction-stream scoreboard, directed corner cases and a randomized run.
module tb_ysyx_22050710_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef YSYX_22050710_IFU_INST_BUF_EN
    localparam int EXP_STALL_REQS = 2;
`else
    localparam int EXP_STALL_REQS = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_22050710_ifu_fetch_if bus ();

    ysyx_22050710_ifu_fetch dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    bit          fixed_data;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          sram_pending;
    int          sram_cnt;
    logic [31:0] sram_req_addr;
    logic [31:0] exp_next_pc;
    bit          prev_hold;
    bit          prev_redir;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    int          n_req;
    int          n_xfer;
    logic        last_en;
    logic [31:0] last_addr;
    logic [31:0] last_xfer_pc;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        if (fixed_data) return pc[2] ? 32'h0000_0013 : 32'h0000_0093;
        return (pc * 32'h9E37_79B9) ^ 32'h1234_5677;
    endfunction

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {inst_of({a[31:3], 3'b100}), inst_of({a[31:3], 3'b000})};
    endfunction

    task automatic cycle(input bit redir, input logic [31:0] tgt, input bit rdy);
        @(posedge clk);
        #1;
        bus.i_sram_rvalid = 1'b0;
        bus.i_sram_rdata  = {$urandom, $urandom};
        if (sram_pending) begin
            sram_cnt--;
            if (sram_cnt == 0) begin
                bus.i_sram_rvalid = 1'b1;
                bus.i_sram_rdata  = mem_word(sram_req_addr);
                sram_pending      = 1'b0;
            end
        end
        bus.i_redirect_valid = redir;
        bus.i_redirect_pc    = tgt;
        bus.i_inst_ready     = rdy;
        #1;
        last_en   = bus.o_sram_en;
        last_addr = bus.o_sram_addr;
        if (prev_redir) check_eq("valid_after_redirect", bus.o_inst_valid, 1'b0);
        if (prev_hold) begin
            check_eq("hold_valid", bus.o_inst_valid, 1'b1);
            check_eq("hold_inst", bus.o_inst, prev_inst);
            check_eq("hold_pc", bus.o_inst_pc, prev_pc);
        end
        if (bus.o_sram_en) begin
            check_eq("req_while_outstanding", {sram_pending, bus.i_sram_rvalid}, 2'b00);
            sram_pending  = 1'b1;
            sram_cnt      = $urandom_range(lat_max, lat_min);
            sram_req_addr = bus.o_sram_addr;
            n_req++;
        end
        if (bus.o_inst_valid && rdy) begin
            check_eq("xfer_pc", bus.o_inst_pc, exp_next_pc);
            check_eq("xfer_inst", bus.o_inst, inst_of(exp_next_pc));
            $display("xfer %0d: pc=%h inst=%h (expect pc=%h inst=%h)",
                     n_xfer, bus.o_inst_pc, bus.o_inst, exp_next_pc, inst_of(exp_next_pc));
            last_xfer_pc = bus.o_inst_pc;
            exp_next_pc  = exp_next_pc + 32'd4;
            n_xfer++;
        end
        if (redir) exp_next_pc = tgt;
        prev_redir = redir;
        prev_hold  = bus.o_inst_valid && !rdy && !redir;
        prev_inst  = bus.o_inst;
        prev_pc    = bus.o_inst_pc;
    endtask

    task automatic do_reset();
        rst_n                = 1'b0;
        bus.i_sram_rvalid    = 1'b0;
        bus.i_sram_rdata     = '0;
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = '0;
        bus.i_inst_ready     = 1'b0;
        sram_pending         = 1'b0;
        exp_next_pc          = RESET_PC;
        prev_hold            = 1'b0;
        prev_redir           = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_sram_en", bus.o_sram_en, 1'b0);
        check_eq("rst_sram_addr", bus.o_sram_addr, RESET_PC);
        check_eq("rst_inst_valid", bus.o_inst_valid, 1'b0);
        check_eq("rst_inst", bus.o_inst, 32'h0);
        check_eq("rst_inst_pc", bus.o_inst_pc, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_req(input bit rdy, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle(1'b0, 32'h0, rdy);
            seen = last_en;
        end
        check_eq(tag, seen, 1'b1);
    endtask

    task automatic run_until_xfer(input int budget, input string tag);
        int start = n_xfer;
        for (int i = 0; i < budget && n_xfer == start; i++) cycle(1'b0, 32'h0, 1'b1);
        check_eq(tag, n_xfer != start, 1'b1);
    endtask

    initial begin
        int base;
        logic [31:0] a0, a1;
        int k;

        // Reset release, fixed SRAM word, 1-cycle latency, ready=1
        fixed_data = 1'b1; lat_min = 1; lat_max = 1;
        do_reset();
        #1;
        check_eq("idle_cycle_en", bus.o_sram_en, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        check_eq("first_req_en", last_en, 1'b1);
        check_eq("first_req_addr", last_addr, RESET_PC);
        base = n_xfer;
        for (int i = 0; i < 10 && n_xfer - base < 2; i++) cycle(1'b0, 32'h0, 1'b1);
        check_eq("first_two_xfers", n_xfer - base, 2);

        // Decode backpressure for 10 cycles, then drain
        fixed_data = 1'b0;
        do_reset();
        base = n_req;
        repeat (10) cycle(1'b0, 32'h0, 1'b0);
        check_eq("stall_req_count", n_req - base, EXP_STALL_REQS);
        base = n_xfer;
        for (int i = 0; i < 40 && n_xfer - base < 6; i++) cycle(1'b0, 32'h0, 1'b1);
        check_eq("drain_xfers", n_xfer - base >= 6, 1'b1);

        // Redirect one cycle after a request; response two cycles after request
        lat_min = 2; lat_max = 2;
        do_reset();
        run_until_req(1'b1, 10, "pre_redir_req");
        cycle(1'b1, 32'h8000_1000, 1'b0);
        run_until_req(1'b1, 10, "redir_req_seen");
        check_eq("redir_req_addr", last_addr, 32'h8000_1000);
        run_until_xfer(10, "redir_xfer_seen");
        check_eq("redir_first_pc", last_xfer_pc, 32'h8000_1000);

        // Redirect in the same cycle as rvalid
        lat_min = 1; lat_max = 1;
        do_reset();
        run_until_req(1'b1, 10, "pre_same_req");
        cycle(1'b1, 32'h8000_2000, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        check_eq("same_cycle_req_en", last_en, 1'b1);
        check_eq("same_cycle_req_addr", last_addr, 32'h8000_2000);
        run_until_xfer(10, "same_cycle_xfer_seen");
        check_eq("same_cycle_first_pc", last_xfer_pc, 32'h8000_2000);

        // Redirect while the buffer is full
        do_reset();
        repeat (10) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h8000_3000, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        check_eq("full_redir_req_en", last_en, 1'b1);
        check_eq("full_redir_req_addr", last_addr, 32'h8000_3000);
        run_until_xfer(10, "full_redir_xfer_seen");
        check_eq("full_redir_first_pc", last_xfer_pc, 32'h8000_3000);

        // PC wrap at the top of the address space
        do_reset();
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        k = 0; a0 = '0; a1 = '1;
        for (int i = 0; i < 12 && k < 2; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (last_en) begin
                if (k == 0) a0 = last_addr; else a1 = last_addr;
                k++;
            end
        end
        check_eq("wrap_first_addr", a0, 32'hFFFF_FFFC);
        check_eq("wrap_next_addr", a1, 32'h0000_0000);

        // Asynchronous reset while a response is outstanding
        lat_min = 3; lat_max = 3;
        do_reset();
        run_until_req(1'b1, 10, "pre_rst_req");
        cycle(1'b0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        sram_pending = 1'b0;
        #1;
        check_eq("midrst_sram_en", bus.o_sram_en, 1'b0);
        check_eq("midrst_sram_addr", bus.o_sram_addr, RESET_PC);
        check_eq("midrst_inst_valid", bus.o_inst_valid, 1'b0);
        check_eq("midrst_inst_pc", bus.o_inst_pc, RESET_PC);
        do_reset();
        cycle(1'b0, 32'h0, 1'b1);
        check_eq("restart_req_en", last_en, 1'b1);
        check_eq("restart_req_addr", last_addr, RESET_PC);

        // Randomized run
        lat_min = 1; lat_max = 3;
        do_reset();
        base = n_xfer;
        for (int i = 0; i < 600; i++) begin
            bit          rd;
            bit          rr;
            logic [31:0] tg;
            rd = ($urandom_range(99, 0) < 4);
            rr = ($urandom_range(99, 0) < 70);
            if ($urandom_range(9, 0) == 0)
                tg = 32'hFFFF_FFF0 + (32'($urandom_range(3, 0)) << 2);
            else
                tg = 32'h8000_0000 + (32'($urandom_range(1023, 0)) << 2);
            cycle(rd, tg, rr);
        end
        check_eq("rand_progress", (n_xfer - base) > 50, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
